config_receiver: RTL and testbench
==================================

CONFIG_RECEIVER -- requirements
Module: config_receiver

Interface
REQ-001 Parameter WORD_W, default 224, sets the configuration word width in bits; it SHALL be a multiple of 8.
REQ-002 Parameter NUM_WORDS, default 43, sets the number of configuration words (tiles) per bitstream.
REQ-003 Parameter SETTLE_CYC, default 10, sets the cycles in each post-load settle phase; it SHALL be at least 1.
REQ-004 Port clock, input, 1 bit: the single clock, rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port abort, input, 1 bit: synchronous load cancel.
REQ-007 Port in_data, input, 8 bits: bitstream byte from the host.
REQ-008 Port in_valid, input, 1 bit: in_data is valid.
REQ-009 Port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-010 Port configs_in, output, WORD_W bits: assembled configuration word for the fabric.
REQ-011 Port configs_en, output, NUM_WORDS bits: one-hot tile write strobe.
REQ-012 Port ff_en, output, 1 bit: enables the fabric flip-flops.
REQ-013 Port rdy, output, 1 bit: the fabric is configured and running.
REQ-014 Port word_idx, output, clog2(NUM_WORDS) bits: index of the word currently being assembled.

Function
REQ-015 A byte SHALL be accepted only on a clock edge where in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL be 1 in states IDLE and SHIFT, and 0 in WRITE, SETTLE, ARM and DONE.
REQ-017 The states SHALL be IDLE, SHIFT, WRITE, SETTLE, ARM and DONE.
REQ-018 IDLE SHALL go to SHIFT on the first accepted byte.
REQ-019 The internal byte counter SHALL count accepted bytes from 0 to WORD_W/8-1 and wrap to 0.
REQ-020 Byte order SHALL be MSB-first: the first byte of a word lands in bits [WORD_W-1:WORD_W-8] and the last byte in bits [7:0].
REQ-021 When the last byte of a word is accepted, the full word SHALL be copied into configs_in on that same edge, and the state SHALL go to WRITE.
REQ-022 configs_in SHALL hold its value until the next word copy; it SHALL NOT change while bytes are being shifted in.
REQ-023 In WRITE, which lasts exactly 1 cycle, configs_en SHALL equal 1<<word_idx; in every other state configs_en SHALL be 0.
REQ-024 On leaving WRITE, the state SHALL go to SETTLE if word_idx==NUM_WORDS-1; otherwise word_idx SHALL increment and the state SHALL return to SHIFT.
REQ-025 Minimum throughput SHALL be WORD_W/8+1 cycles per word; host stalls (in_valid=0) SHALL insert cycles with no state or data loss.
REQ-026 SETTLE SHALL last exactly SETTLE_CYC cycles; ff_en SHALL then be set to 1 and the state SHALL go to ARM.
REQ-027 ARM SHALL last exactly SETTLE_CYC cycles; rdy SHALL then be set to 1 and the state SHALL go to DONE.
REQ-028 DONE SHALL be terminal, with in_ready=0, ff_en=1 and rdy=1; bytes offered in DONE SHALL be ignored.
REQ-029 abort=1 in any state SHALL, on the next edge, return the block to IDLE with all outputs at reset values, except configs_in, which holds its value.
REQ-030 If abort and an accepted byte occur on the same edge, abort SHALL win and the byte SHALL be discarded.
REQ-031 word_idx SHALL never exceed NUM_WORDS-1.

Reset
REQ-032 While rst=0, all outputs SHALL be asynchronously 0: in_ready, configs_in, configs_en, ff_en, rdy and word_idx; the state SHALL be IDLE and the byte counter 0.
REQ-033 On the first edge after rst rises, in_ready SHALL be 1.
REQ-034 rst asserted mid-load or mid-settle SHALL discard the partial word and the progress count; a new load SHALL start at word 0.

Verification (parameters WORD_W=16, NUM_WORDS=3, SETTLE_CYC=2 unless noted)
REQ-035 Back-to-back bytes 0xA1 0xB2, 0xC3 0xD4, 0xE5 0xF6 -> configs_in=0xA1B2 with configs_en=001, then 0xC3D4 with 010, then 0xE5F6 with 100, each strobe exactly 1 cycle; ff_en rises 2 cycles after the last WRITE and rdy rises 2 cycles after ff_en.
REQ-036 in_valid toggling 1/0 each cycle -> identical words and strobes, stretched in time; no byte lost or duplicated.
REQ-037 abort asserted after byte 3 -> IDLE, configs_en=0, word_idx=0; a subsequent full 6-byte load completes correctly from word 0.
REQ-038 rst driven low during SETTLE -> ff_en=0, rdy=0, in_ready=0 immediately, without waiting for a clock edge.
REQ-039 Bytes offered in DONE -> in_ready=0, configs_in and configs_en unchanged, rdy remains 1.
REQ-040 Default parameters, 43x28 random bytes -> exactly 43 single-cycle one-hot strobes, in order bit 0 to bit 42, each with the matching 224-bit word; rdy=1 at the end.

Source files
------------

// File: rtl/config_receiver.sv
// Configuration bitstream receiver: packs MSB-first host bytes into WORD_W-bit tile words,
// strobes each tile once in order, then runs settle and arm phases before flagging ready.
module config_receiver #(
   parameter int  WORD_W     = 224,
   parameter int  NUM_WORDS  = 43,
   parameter int  SETTLE_CYC = 10,
   localparam int IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
   input  logic                 clock,
   input  logic                 rst,
   input  logic                 abort,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WORD_W-1:0]    configs_in,
   output logic [NUM_WORDS-1:0] configs_en,
   output logic                 ff_en,
   output logic                 rdy,
   output logic [IDX_W-1:0]     word_idx
);

   localparam int BYTES = WORD_W / 8;
   localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [NUM_WORDS-1:0] ONE = NUM_WORDS'(1);

   typedef enum logic [2:0] {IDLE, SHIFT, WRITE, SETTLE, ARM, DONE} state_t;

   state_t                 state_q;
   logic [CNT_W-1:0]       byteCnt_q;
   logic [SET_W-1:0]       settleCnt_q;
   logic [WORD_W-1:0]      shift_q;
   logic [WORD_W-1:0]      configsIn_q;
   logic [NUM_WORDS-1:0]   configsEn_q;
   logic [IDX_W-1:0]       wordIdx_q;
   logic                   inReady_q;
   logic                   ffEn_q;
   logic                   rdy_q;

   logic                   accept;
   logic                   lastByte;
   logic                   lastWord;
   logic                   settleDone;
   logic [WORD_W-1:0]      shift_d;
   logic [NUM_WORDS-1:0]   strobe_d;

   always_comb begin
      accept     = in_valid && inReady_q;
      lastByte   = (byteCnt_q == CNT_W'(BYTES - 1));
      lastWord   = (wordIdx_q == IDX_W'(NUM_WORDS - 1));
      settleDone = (settleCnt_q == SET_W'(SETTLE_CYC - 1));
      shift_d    = WORD_W'({shift_q, in_data});
      strobe_d   = ONE << wordIdx_q;
   end

   // Abort takes priority over any byte on the same edge; configs_in deliberately survives it.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         byteCnt_q   <= '0;
         settleCnt_q <= '0;
         shift_q     <= '0;
         configsIn_q <= '0;
         configsEn_q <= '0;
         wordIdx_q   <= '0;
         inReady_q   <= 1'b0;
         ffEn_q      <= 1'b0;
         rdy_q       <= 1'b0;
      end else if (abort) begin
         state_q     <= IDLE;
         byteCnt_q   <= '0;
         settleCnt_q <= '0;
         shift_q     <= '0;
         configsEn_q <= '0;
         wordIdx_q   <= '0;
         inReady_q   <= 1'b0;
         ffEn_q      <= 1'b0;
         rdy_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE, SHIFT: begin
               inReady_q <= 1'b1;
               if (accept) begin
                  shift_q <= shift_d;
                  if (lastByte) begin
                     byteCnt_q   <= '0;
                     configsIn_q <= shift_d;
                     configsEn_q <= strobe_d;
                     inReady_q   <= 1'b0;
                     state_q     <= WRITE;
                  end else begin
                     byteCnt_q <= byteCnt_q + CNT_W'(1);
                     state_q   <= SHIFT;
                  end
               end
            end
            WRITE: begin
               configsEn_q <= '0;
               if (lastWord) begin
                  settleCnt_q <= '0;
                  state_q     <= SETTLE;
               end else begin
                  wordIdx_q <= wordIdx_q + IDX_W'(1);
                  inReady_q <= 1'b1;
                  state_q   <= SHIFT;
               end
            end
            SETTLE: begin
               if (settleDone) begin
                  settleCnt_q <= '0;
                  ffEn_q      <= 1'b1;
                  state_q     <= ARM;
               end else begin
                  settleCnt_q <= settleCnt_q + SET_W'(1);
               end
            end
            ARM: begin
               if (settleDone) begin
                  settleCnt_q <= '0;
                  rdy_q       <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  settleCnt_q <= settleCnt_q + SET_W'(1);
               end
            end
            DONE: begin
               inReady_q <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready   = inReady_q;
   assign configs_in = configsIn_q;
   assign configs_en = configsEn_q;
   assign ff_en      = ffEn_q;
   assign rdy        = rdy_q;
   assign word_idx   = wordIdx_q;

   // Structural invariants of the receiver.
   assert property (@(posedge clock) disable iff (!rst) wordIdx_q <= IDX_W'(NUM_WORDS - 1));
   assert property (@(posedge clock) disable iff (!rst) $onehot0(configsEn_q));
   assert property (@(posedge clock) disable iff (!rst)
                    inReady_q |-> (state_q == IDLE || state_q == SHIFT));

endmodule

// File: tb/tb_config_receiver.sv
// Bench for config_receiver: a small instance (16/3/2) for directed scenarios and a
// default-parameter instance for a long randomized load, both checked against a byte-queue model.
module tb_config_receiver;

   localparam int SW = 16;
   localparam int SN = 3;
   localparam int SS = 2;
   localparam int BW = 224;
   localparam int BN = 43;
   localparam int BB = BW / 8;

   logic clock = 1'b0;
   logic rst = 1'b0;

   logic          abort = 1'b0;
   logic          inValid = 1'b0;
   logic [7:0]    inData = 8'h00;
   logic          inReady;
   logic [SW-1:0] configsIn;
   logic [SN-1:0] configsEn;
   logic          ffEn;
   logic          rdy;
   logic [1:0]    wordIdx;

   logic          bigAbort = 1'b0;
   logic          bigValid = 1'b0;
   logic [7:0]    bigData = 8'h00;
   logic          bigReady;
   logic [BW-1:0] bigConfigsIn;
   logic [BN-1:0] bigConfigsEn;
   logic          bigFfEn;
   logic          bigRdy;
   logic [5:0]    bigWordIdx;

   int checks = 0;
   int errors = 0;

   int            cycle = 0;
   logic [SN-1:0] enLog[$];
   logic [SW-1:0] wordLog[$];
   int            cycLog[$];
   int            ffRiseLog[$];
   int            rdyRiseLog[$];
   int            holdViol = 0;
   logic          ffPrev = 1'b0;
   logic          rdyPrev = 1'b0;
   logic          rstPrev = 1'b0;
   logic [SW-1:0] cfgPrev = '0;

   logic [BN-1:0] bigEnLog[$];
   logic [BW-1:0] bigWordLog[$];

   logic [7:0]    txQ[$];
   logic [7:0]    sentQ[$];

   config_receiver #(.WORD_W(SW), .NUM_WORDS(SN), .SETTLE_CYC(SS)) dut (
      .clock      (clock),
      .rst        (rst),
      .abort      (abort),
      .in_data    (inData),
      .in_valid   (inValid),
      .in_ready   (inReady),
      .configs_in (configsIn),
      .configs_en (configsEn),
      .ff_en      (ffEn),
      .rdy        (rdy),
      .word_idx   (wordIdx)
   );

   config_receiver dutBig (
      .clock      (clock),
      .rst        (rst),
      .abort      (bigAbort),
      .in_data    (bigData),
      .in_valid   (bigValid),
      .in_ready   (bigReady),
      .configs_in (bigConfigsIn),
      .configs_en (bigConfigsEn),
      .ff_en      (bigFfEn),
      .rdy        (bigRdy),
      .word_idx   (bigWordIdx)
   );

   always #5 clock = ~clock;

   // Records every strobe sample and phase edge so scenarios can compare against the byte model.
   always @(negedge clock) begin
      cycle <= cycle + 1;
      if (configsEn != '0) begin
         enLog.push_back(configsEn);
         wordLog.push_back(configsIn);
         cycLog.push_back(cycle);
      end
      if (bigConfigsEn != '0) begin
         bigEnLog.push_back(bigConfigsEn);
         bigWordLog.push_back(bigConfigsIn);
      end
      if (ffEn && !ffPrev) ffRiseLog.push_back(cycle);
      if (rdy && !rdyPrev) rdyRiseLog.push_back(cycle);
      if (rst && rstPrev && configsEn == '0 && configsIn !== cfgPrev) holdViol <= holdViol + 1;
      ffPrev  <= ffEn;
      rdyPrev <= rdy;
      rstPrev <= rst;
      cfgPrev <= configsIn;
   end

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   function automatic logic pickValid(input int mode, input int n);
      case (mode)
         0:       return 1'b1;
         1:       return 1'((n % 2) == 0);
         default: return 1'($urandom_range(0, 3) != 0);
      endcase
   endfunction

   task automatic fill(input int n);
      for (int i = 0; i < n; i++) txQ.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic stream(input bit big, input int mode);
      int n = 0;
      while (txQ.size() > 0 && n < 20000) begin
         step();
         if (big) begin
            bigValid = pickValid(mode, n);
            bigData  = txQ[0];
            if (bigValid && bigReady) sentQ.push_back(txQ.pop_front());
         end else begin
            inValid = pickValid(mode, n);
            inData  = txQ[0];
            if (inValid && inReady) sentQ.push_back(txQ.pop_front());
         end
         n++;
      end
      step();
      inValid  = 1'b0;
      bigValid = 1'b0;
      checks++;
      if (txQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL stream_drain: %0d bytes left, expected 0", txQ.size());
         txQ.delete();
      end
   endtask

   task automatic waitRdy(input bit big, input int limit);
      int n = 0;
      while (!(big ? bigRdy : rdy) && n < limit) begin
         step();
         n++;
      end
      checks++;
      if (!(big ? bigRdy : rdy)) begin
         errors++;
         $display("[TB] FAIL rdy_timeout: rdy=0 after %0d cycles, expected 1", limit);
      end
   endtask

   task automatic doReset();
      step();
      rst = 1'b0;
      abort = 1'b0;
      inValid = 1'b0;
      bigValid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
   endtask

   // Model: word k is bytes 2k,2k+1 of the accepted stream, strobed on bit k, in order.
   task automatic checkSmall(input int base, input string tag);
      logic [SN-1:0] expEn;
      logic [SW-1:0] expWord;
      checks++;
      if (enLog.size() - base != SN) begin
         errors++;
         $display("[TB] FAIL %s_strobes: got %0d, expected %0d", tag, enLog.size() - base, SN);
      end
      for (int k = 0; k < SN; k++) begin
         if (base + k < enLog.size() && 2 * k + 1 < sentQ.size()) begin
            expEn = '0;
            expEn[k] = 1'b1;
            expWord = {sentQ[2 * k], sentQ[2 * k + 1]};
            checks++;
            if (enLog[base + k] !== expEn) begin
               errors++;
               $display("[TB] FAIL %s_en%0d: got %b, expected %b", tag, k, enLog[base + k], expEn);
            end
            checks++;
            if (wordLog[base + k] !== expWord) begin
               errors++;
               $display("[TB] FAIL %s_word%0d: got %h, expected %h", tag, k, wordLog[base + k], expWord);
            end
         end
      end
   endtask

   task automatic test_reset();
      step();
      checks += 6;
      if (inReady !== 1'b0)  begin errors++; $display("[TB] FAIL reset_in_ready: got %b, expected 0", inReady); end
      if (configsIn !== '0)  begin errors++; $display("[TB] FAIL reset_configs_in: got %h, expected 0", configsIn); end
      if (configsEn !== '0)  begin errors++; $display("[TB] FAIL reset_configs_en: got %b, expected 0", configsEn); end
      if (ffEn !== 1'b0)     begin errors++; $display("[TB] FAIL reset_ff_en: got %b, expected 0", ffEn); end
      if (rdy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_rdy: got %b, expected 0", rdy); end
      if (wordIdx !== 2'd0)  begin errors++; $display("[TB] FAIL reset_word_idx: got %0d, expected 0", wordIdx); end
      rst = 1'b1;
      step();
      checks++;
      if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready: got %b, expected 1", inReady); end
   endtask

   task automatic test_back_to_back();
      int base = enLog.size();
      int ffBase = ffRiseLog.size();
      int rdyBase = rdyRiseLog.size();
      int hold0 = holdViol;
      sentQ.delete();
      txQ = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
      stream(1'b0, 0);
      waitRdy(1'b0, 50);
      checkSmall(base, "b2b");
      checks++;
      if (sentQ.size() != 6 || sentQ[0] !== 8'hA1 || sentQ[5] !== 8'hF6) begin
         errors++;
         $display("[TB] FAIL b2b_accepted: got %0d bytes, expected 6 in order", sentQ.size());
      end
      if (enLog.size() - base == SN) begin
         for (int k = 1; k < SN; k++) begin
            checks++;
            if (cycLog[base + k] - cycLog[base + k - 1] != SW / 8 + 1) begin
               errors++;
               $display("[TB] FAIL b2b_spacing%0d: got %0d cycles, expected %0d", k,
                        cycLog[base + k] - cycLog[base + k - 1], SW / 8 + 1);
            end
         end
         checks++;
         if (ffRiseLog.size() != ffBase + 1 || ffRiseLog[ffBase] - cycLog[base + SN - 1] != SS + 1) begin
            errors++;
            $display("[TB] FAIL b2b_ff_en_delay: got %0d rises, expected ff_en %0d samples after last strobe",
                     ffRiseLog.size() - ffBase, SS + 1);
         end
         checks++;
         if (rdyRiseLog.size() != rdyBase + 1 || ffRiseLog.size() != ffBase + 1 ||
             rdyRiseLog[rdyBase] - ffRiseLog[ffBase] != SS) begin
            errors++;
            $display("[TB] FAIL b2b_rdy_delay: got %0d rises, expected rdy %0d cycles after ff_en",
                     rdyRiseLog.size() - rdyBase, SS);
         end
      end
      checks += 4;
      if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_ready: got %b, expected 0", inReady); end
      if (ffEn !== 1'b1)    begin errors++; $display("[TB] FAIL b2b_done_ff_en: got %b, expected 1", ffEn); end
      if (wordIdx !== 2'd2) begin errors++; $display("[TB] FAIL b2b_done_idx: got %0d, expected 2", wordIdx); end
      if (holdViol != hold0) begin errors++; $display("[TB] FAIL b2b_hold: got %0d changes, expected 0", holdViol - hold0); end
   endtask

   task automatic test_stall();
      int base;
      int hold0;
      doReset();
      base = enLog.size();
      hold0 = holdViol;
      sentQ.delete();
      fill(6);
      stream(1'b0, 1);
      waitRdy(1'b0, 50);
      checkSmall(base, "stall");
      checks++;
      if (holdViol != hold0) begin errors++; $display("[TB] FAIL stall_hold: got %0d changes, expected 0", holdViol - hold0); end
   endtask

   task automatic test_abort();
      int base;
      logic [SW-1:0] held;
      doReset();
      base = enLog.size();
      sentQ.delete();
      fill(3);
      stream(1'b0, 0);
      held = {sentQ[0], sentQ[1]};
      step();
      abort   = 1'b1;
      inValid = 1'b1;
      inData  = 8'($urandom_range(0, 255));
      step();
      abort   = 1'b0;
      inValid = 1'b0;
      checks += 6;
      if (enLog.size() - base != 1) begin errors++; $display("[TB] FAIL abort_pre_strobes: got %0d, expected 1", enLog.size() - base); end
      if (configsEn !== '0)  begin errors++; $display("[TB] FAIL abort_configs_en: got %b, expected 0", configsEn); end
      if (wordIdx !== 2'd0)  begin errors++; $display("[TB] FAIL abort_word_idx: got %0d, expected 0", wordIdx); end
      if (ffEn !== 1'b0)     begin errors++; $display("[TB] FAIL abort_ff_en: got %b, expected 0", ffEn); end
      if (rdy !== 1'b0)      begin errors++; $display("[TB] FAIL abort_rdy: got %b, expected 0", rdy); end
      if (configsIn !== held) begin errors++; $display("[TB] FAIL abort_configs_hold: got %h, expected %h", configsIn, held); end
      base = enLog.size();
      sentQ.delete();
      fill(6);
      stream(1'b0, 2);
      waitRdy(1'b0, 50);
      checkSmall(base, "abort_reload");
   endtask

   task automatic test_rst_settle();
      int base;
      int n = 0;
      doReset();
      base = enLog.size();
      sentQ.delete();
      fill(6);
      stream(1'b0, 0);
      while (enLog.size() - base < SN && n < 20) begin
         step();
         n++;
      end
      step();
      rst = 1'b0;
      #1;
      checks += 6;
      if (ffEn !== 1'b0)    begin errors++; $display("[TB] FAIL rst_settle_ff_en: got %b, expected 0", ffEn); end
      if (rdy !== 1'b0)     begin errors++; $display("[TB] FAIL rst_settle_rdy: got %b, expected 0", rdy); end
      if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL rst_settle_ready: got %b, expected 0", inReady); end
      if (wordIdx !== 2'd0) begin errors++; $display("[TB] FAIL rst_settle_idx: got %0d, expected 0", wordIdx); end
      if (configsIn !== '0) begin errors++; $display("[TB] FAIL rst_settle_cfg: got %h, expected 0", configsIn); end
      if (configsEn !== '0) begin errors++; $display("[TB] FAIL rst_settle_en: got %b, expected 0", configsEn); end
      step();
      rst = 1'b1;
      step();
      fill(1);
      stream(1'b0, 0);
      doReset();
      base = enLog.size();
      sentQ.delete();
      fill(6);
      stream(1'b0, 2);
      waitRdy(1'b0, 50);
      checkSmall(base, "rst_reload");
   endtask

   task automatic test_done();
      int base;
      int hold0;
      logic [SW-1:0] lastWord;
      doReset();
      base = enLog.size();
      sentQ.delete();
      fill(6);
      stream(1'b0, 2);
      waitRdy(1'b0, 50);
      checkSmall(base, "done_load");
      lastWord = {sentQ[4], sentQ[5]};
      hold0 = holdViol;
      for (int i = 0; i < 4; i++) begin
         step();
         checks += 4;
         if (inReady !== 1'b0)     begin errors++; $display("[TB] FAIL done_ready%0d: got %b, expected 0", i, inReady); end
         if (rdy !== 1'b1)         begin errors++; $display("[TB] FAIL done_rdy%0d: got %b, expected 1", i, rdy); end
         if (configsEn !== '0)     begin errors++; $display("[TB] FAIL done_en%0d: got %b, expected 0", i, configsEn); end
         if (configsIn !== lastWord) begin errors++; $display("[TB] FAIL done_cfg%0d: got %h, expected %h", i, configsIn, lastWord); end
         inValid = 1'b1;
         inData  = 8'($urandom_range(0, 255));
      end
      step();
      inValid = 1'b0;
      checks += 2;
      if (enLog.size() - base != SN) begin errors++; $display("[TB] FAIL done_extra_strobes: got %0d, expected %0d", enLog.size() - base, SN); end
      if (holdViol != hold0) begin errors++; $display("[TB] FAIL done_hold: got %0d changes, expected 0", holdViol - hold0); end
      rst = 1'b0;
      #1;
      checks += 2;
      if (ffEn !== 1'b0) begin errors++; $display("[TB] FAIL done_async_ff_en: got %b, expected 0", ffEn); end
      if (rdy !== 1'b0)  begin errors++; $display("[TB] FAIL done_async_rdy: got %b, expected 0", rdy); end
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_random_default();
      int base;
      logic [BN-1:0] expEn;
      logic [BW-1:0] expWord;
      doReset();
      base = bigEnLog.size();
      sentQ.delete();
      fill(BN * BB);
      stream(1'b1, 2);
      waitRdy(1'b1, 200);
      checks++;
      if (bigEnLog.size() - base != BN) begin
         errors++;
         $display("[TB] FAIL big_strobes: got %0d, expected %0d", bigEnLog.size() - base, BN);
      end
      for (int k = 0; k < BN; k++) begin
         if (base + k < bigEnLog.size() && (k + 1) * BB <= sentQ.size()) begin
            expEn = '0;
            expEn[k] = 1'b1;
            expWord = '0;
            for (int j = 0; j < BB; j++) expWord = {expWord[BW-9:0], sentQ[k * BB + j]};
            checks++;
            if (bigEnLog[base + k] !== expEn) begin
               errors++;
               $display("[TB] FAIL big_en%0d: got %h, expected %h", k, bigEnLog[base + k], expEn);
            end
            checks++;
            if (bigWordLog[base + k] !== expWord) begin
               errors++;
               $display("[TB] FAIL big_word%0d: got %h, expected %h", k, bigWordLog[base + k], expWord);
            end
         end
      end
      checks += 3;
      if (bigRdy !== 1'b1)       begin errors++; $display("[TB] FAIL big_rdy: got %b, expected 1", bigRdy); end
      if (bigFfEn !== 1'b1)      begin errors++; $display("[TB] FAIL big_ff_en: got %b, expected 1", bigFfEn); end
      if (bigWordIdx !== 6'd42)  begin errors++; $display("[TB] FAIL big_word_idx: got %0d, expected 42", bigWordIdx); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_abort();
      test_rst_settle();
      test_done();
      test_random_default();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
